fpu_result_collector: RTL

- Downstream stage of the FPU top: captures the add/sub or mul result (Sz, Ez, Mz plus five exception flags) a fixed number of cycles after each issue.
- Packs each result into an IEEE-754 single word and buffers it in a small FWFT FIFO with a valid/ready output.
- Gives the issuing logic credit-based backpressure.
- Keeps a sticky, software-clearable accumulation of exception flags, like a status register.

---
 rtl/fpu_result_collector.sv | 122 ++++++++++++
 1 files changed

// File: rtl/fpu_result_collector.sv
// Result collector behind the FPU: tracks issues through the fixed FPU latency,
// packs results into IEEE-754 words, buffers them in a FWFT FIFO with credit backpressure.
module fpu_result_collector #(
  parameter int LATENCY = 3,
  parameter int DEPTH   = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        issue_valid,
  input  logic        issue_op,
  output logic        issue_ready,
  input  logic [7:0]  Ez,
  input  logic [22:0] Mz,
  input  logic        Sz,
  input  logic [4:0]  fpu_flags,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [31:0] res_word,
  output logic [4:0]  res_flags,
  output logic        res_op,
  output logic [4:0]  sticky_flags,
  input  logic        clr_sticky,
  output logic        drop_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int SW = $clog2(DEPTH + LATENCY + 1);

  // Handshakes: an issue is taken on issue_valid && issue_ready; a result leaves
  // the FIFO on res_valid && res_ready. Both take effect on the rising edge.

  logic [LATENCY-1:0] trk_vld;
  logic [LATENCY-1:0] trk_op;
  logic [SW-1:0]      inflight;
  logic [CW-1:0]      occ;
  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      rd_ptr;
  logic [37:0]        mem [DEPTH];
  logic [37:0]        head;
  logic               accept;
  logic               push;
  logic               pop;

  always_comb begin
    inflight = '0;
    for (int i = 0; i < LATENCY; i++) begin
      inflight = inflight + SW'(trk_vld[i]);
    end
  end

  // Credit counts results still inside the FPU as already occupying the FIFO.
  assign issue_ready = (inflight + SW'(occ)) < SW'(DEPTH);
  assign accept      = issue_valid & issue_ready;
  assign push        = trk_vld[LATENCY-1];
  assign res_valid   = (occ != '0);
  assign pop         = res_valid & res_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      trk_vld <= '0;
      trk_op  <= '0;
    end else begin
      for (int i = 0; i < LATENCY; i++) begin
        if (i == 0) begin
          trk_vld[i] <= accept;
          trk_op[i]  <= issue_op;
        end else begin
          trk_vld[i] <= trk_vld[i-1];
          trk_op[i]  <= trk_op[i-1];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= {trk_op[LATENCY-1], fpu_flags, Sz, Ez, Mz};
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   occ <= occ + CW'(1);
        2'b01:   occ <= occ - CW'(1);
        default: occ <= occ;
      endcase
    end
  end

  assign head      = mem[rd_ptr];
  assign res_word  = head[31:0];
  assign res_flags = head[36:32];
  assign res_op    = head[37];

  // A clear coinciding with a push keeps only that push's flags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sticky_flags <= '0;
      drop_err     <= 1'b0;
    end else begin
      if (push) begin
        sticky_flags <= (clr_sticky ? 5'b0 : sticky_flags) | fpu_flags;
      end else if (clr_sticky) begin
        sticky_flags <= '0;
      end
      if (issue_valid && !issue_ready) begin
        drop_err <= 1'b1;
      end
    end
  end

endmodule
